pe_feeder: RTL and testbench
============================

PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 Parameter IMG_W, default 5, image width in pixels (>=3).
REQ-002 Parameter IMG_H, default 5, image height in pixels (>=3).
REQ-003 Parameter TIMEOUT, default 16, max cycles to wait for pe_count_9 after last pair.
REQ-004 clk  in  1  clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  one-cycle pulse; begins convolution of whole image.
REQ-007 busy  out  1  high from accepted start until done.
REQ-008 done  out  1  one-cycle pulse at end of run.
REQ-009 err  out  1  sticky timeout flag; cleared by next accepted start.
REQ-010 img_addr  out  AW=clog2(IMG_W*IMG_H)  image buffer read address.
REQ-011 img_data  in  8  image read data, valid 1 cycle after img_addr.
REQ-012 flt_addr  out  4  filter buffer address 0..8.
REQ-013 flt_data  in  8  filter read data, valid 1 cycle after flt_addr.
REQ-014 pe_in  out  8  pixel to PE; pe_filter  out  8  weight to PE.
REQ-015 mode_o  out  2  PE accumulate control: 2'b01 pair valid, 2'b00 idle.
REQ-016 pe_result  in  8  PE accumulator output; pe_count_9  in  1  PE 9th-product flag.
REQ-017 res_valid  out  1; res_ready  in  1; res_data  out  8; res_addr  out  RW=clog2((IMG_W-2)*(IMG_H-2)).

Function
REQ-018 Valid (no padding) 3x3 convolution: output windows r=0..IMG_H-3, c=0..IMG_W-3, row-major order.
REQ-019 Per window, tap k=0..8: flt_addr=k, img_addr=(r+k/3)*IMG_W+(c+k%3), one tap per cycle, 9 consecutive cycles.
REQ-020 pe_in=img_data, pe_filter=flt_data combinationally; mode_o=2'b01 exactly in the 9 cycles following each tap address, else 2'b00.
REQ-021 FSM states IDLE, FETCH, WAIT, OUT, FIN; IDLE->FETCH on start.
REQ-022 FETCH->WAIT after tap 8 address issued; WAIT->OUT on pe_count_9=1, registering pe_result.
REQ-023 WAIT counter exceeding TIMEOUT: set err, abort run, go FIN.
REQ-024 OUT: res_valid=1, res_data/res_addr stable until res_valid&&res_ready; then FETCH next window or FIN after last.
REQ-025 res_addr=r*(IMG_W-2)+c.
REQ-026 FIN: done=1 for one cycle, busy=0 next cycle, return to IDLE.
REQ-027 start while busy ignored; start in FIN cycle ignored.
REQ-028 res_data is 8-bit, modulo-256 as delivered by PE; no saturation in this block.
REQ-029 pe_count_9 outside WAIT ignored.

Reset
REQ-030 rst asserted: FSM to IDLE, all counters 0, busy=0, done=0, err=0, res_valid=0, res_data=0, res_addr=0, img_addr=0, flt_addr=0, mode_o=2'b00.
REQ-031 rst mid-run aborts immediately; no res_valid or done issued for aborted run.

Configuration
REQ-032 Macro PE_FEEDER_RELU_EN defined: registered result with bit7=1 written as res_data=8'h00 (signed ReLU).
REQ-033 Macro PE_FEEDER_RELU_EN undefined: res_data equals registered pe_result unchanged.

Verification
REQ-034 5x5 image all 8'h01, filter all 8'h01, res_ready=1 -> 9 results, each 8'h09, res_addr 0..8 in order, one done pulse, err=0.
REQ-035 Image all 8'h10, filter all 8'h02 -> every res_data=8'h20 (288 mod 256).
REQ-036 Result 8'h90 -> res_data=8'h00 with PE_FEEDER_RELU_EN, 8'h90 without.
REQ-037 res_ready held low 5 cycles in OUT -> res_valid stays 1, res_data/res_addr unchanged, no new img_addr activity until accept.
REQ-038 pe_count_9 tied 0 -> after TIMEOUT+1 WAIT cycles err=1, done pulse, zero results issued; next start clears err.
REQ-039 rst pulse during FETCH of window 4 -> all outputs at reset values; fresh start yields full 9-result run.

Source files
------------

// File: rtl/pe_feeder.sv
// rtl/pe_feeder.sv - 3x3 valid-convolution sequencer feeding one MAC PE, with result handshake
// Optional feature: define PE_FEEDER_RELU_EN to zero results whose bit 7 is set.
module pe_feeder #(
  parameter int IMG_W   = 5,
  parameter int IMG_H   = 5,
  parameter int TIMEOUT = 16,
  localparam int AW     = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1,
  localparam int NWIN   = (IMG_W - 2) * (IMG_H - 2),
  localparam int RW     = (NWIN > 1) ? $clog2(NWIN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] img_addr,
  input  logic [7:0]    img_data,
  output logic [3:0]    flt_addr,
  input  logic [7:0]    flt_data,
  output logic [7:0]    pe_in,
  output logic [7:0]    pe_filter,
  output logic [1:0]    mode_o,
  input  logic [7:0]    pe_result,
  input  logic          pe_count_9,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [7:0]    res_data,
  output logic [RW-1:0] res_addr
);

  localparam int WCW = $clog2(TIMEOUT + 2);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, OUT, FIN} state_t;

  state_t         state_q;
  logic [AW-1:0]  base_q;
  logic [AW-1:0]  img_addr_q;
  logic [AW-1:0]  tap_next_d;
  logic [AW-1:0]  base_next_d;
  logic [3:0]     flt_addr_q;
  logic [1:0]     kc_q;
  logic [1:0]     mode_q;
  logic [15:0]    c_q;
  logic [RW-1:0]  win_q;
  logic [RW-1:0]  res_addr_q;
  logic [WCW-1:0] wait_q;
  logic           busy_q;
  logic           done_q;
  logic           err_q;
  logic           res_valid_q;
  logic [7:0]     res_data_q;
  logic [7:0]     res_data_d;
  logic           last_win;

  // Addresses advance incrementally: +1 along a row, jump to the next row start at the edge.
  always_comb begin
    tap_next_d  = (kc_q == 2'd2) ? img_addr_q + AW'(IMG_W - 2) : img_addr_q + AW'(1);
    base_next_d = (c_q == 16'(IMG_W - 3)) ? base_q + AW'(3) : base_q + AW'(1);
    res_data_d  = pe_result;
`ifdef PE_FEEDER_RELU_EN
    if (pe_result[7]) res_data_d = 8'h00;
`endif
  end

  assign last_win = (win_q == RW'(NWIN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      img_addr_q  <= '0;
      flt_addr_q  <= '0;
      kc_q        <= '0;
      mode_q      <= 2'b00;
      c_q         <= '0;
      win_q       <= '0;
      res_addr_q  <= '0;
      wait_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      mode_q <= 2'b00;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
            base_q     <= '0;
            img_addr_q <= '0;
            flt_addr_q <= '0;
            kc_q       <= '0;
            c_q        <= '0;
            win_q      <= '0;
            state_q    <= FETCH;
          end
        end
        FETCH: begin
          // Data for the address shown now arrives next cycle, so the PE pair is valid then.
          mode_q <= 2'b01;
          if (flt_addr_q == 4'd8) begin
            wait_q  <= '0;
            state_q <= WAIT;
          end else begin
            img_addr_q <= tap_next_d;
            flt_addr_q <= flt_addr_q + 4'd1;
            kc_q       <= (kc_q == 2'd2) ? 2'd0 : kc_q + 2'd1;
          end
        end
        WAIT: begin
          if (pe_count_9) begin
            res_data_q  <= res_data_d;
            res_addr_q  <= win_q;
            res_valid_q <= 1'b1;
            state_q     <= OUT;
          end else if (wait_q == WCW'(TIMEOUT)) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            wait_q <= wait_q + WCW'(1);
          end
        end
        OUT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            if (last_win) begin
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              win_q      <= win_q + RW'(1);
              base_q     <= base_next_d;
              img_addr_q <= base_next_d;
              flt_addr_q <= '0;
              kc_q       <= '0;
              c_q        <= (c_q == 16'(IMG_W - 3)) ? 16'd0 : c_q + 16'd1;
              state_q    <= FETCH;
            end
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign img_addr  = img_addr_q;
  assign flt_addr  = flt_addr_q;
  assign pe_in     = img_data;
  assign pe_filter = flt_data;
  assign mode_o    = mode_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_addr  = res_addr_q;

endmodule

// File: tb/tb_pe_feeder.sv
// tb/tb_pe_feeder.sv - self-checking bench for pe_feeder with image/filter memories and a MAC PE model
module tb_pe_feeder;
  localparam int W    = 5;
  localparam int H    = 5;
  localparam int TO   = 16;
  localparam int AW   = 5;
  localparam int RW   = 4;
  localparam int NWIN = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, err;
  logic [AW-1:0] img_addr;
  logic [7:0]    img_data;
  logic [3:0]    flt_addr;
  logic [7:0]    flt_data;
  logic [7:0]    pe_in, pe_filter;
  logic [1:0]    mode_o;
  logic [7:0]    pe_result;
  logic          pe_count_9;
  logic          res_valid, res_ready;
  logic [7:0]    res_data;
  logic [RW-1:0] res_addr;

  int tests  = 0;
  int failed = 0;

  logic [7:0] img_mem [W*H];
  logic [7:0] flt_mem [9];
  int         pe_cnt;
  logic [7:0] pe_acc;
  bit         pe_kill = 1'b0;

  pe_feeder #(.IMG_W(W), .IMG_H(H), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .img_addr(img_addr), .img_data(img_data), .flt_addr(flt_addr), .flt_data(flt_data),
    .pe_in(pe_in), .pe_filter(pe_filter), .mode_o(mode_o), .pe_result(pe_result),
    .pe_count_9(pe_count_9), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_addr(res_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    img_data <= img_mem[int'(img_addr) % (W*H)];
    flt_data <= flt_mem[int'(flt_addr) % 9];
  end

  // PE: accumulates while mode is 01, restarting after each group of nine products.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pe_cnt <= 0;
      pe_acc <= 8'h00;
    end else if (mode_o == 2'b01) begin
      if (pe_cnt >= 9) begin
        pe_acc <= 8'(int'(pe_in) * int'(pe_filter));
        pe_cnt <= 1;
      end else begin
        pe_acc <= 8'(int'(pe_acc) + int'(pe_in) * int'(pe_filter));
        pe_cnt <= pe_cnt + 1;
      end
    end
  end
  assign pe_result  = pe_acc;
  assign pe_count_9 = !pe_kill && (pe_cnt == 9);

  function automatic logic [7:0] ref_win(input int r, input int c);
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += int'(img_mem[(r + i) * W + c + j]) * int'(flt_mem[i * 3 + j]);
    s = s % 256;
`ifdef PE_FEEDER_RELU_EN
    if (s >= 128) s = 0;
`endif
    return 8'(s);
  endfunction

  task automatic fill(input int kind);
    for (int i = 0; i < W*H; i++)
      img_mem[i] = (kind == 0) ? 8'h01 : (kind == 3) ? 8'($urandom_range(0, 255)) : 8'h10;
    for (int i = 0; i < 9; i++)
      flt_mem[i] = (kind == 0) ? 8'h01 : (kind == 1) ? 8'h02 : (kind == 2) ? 8'h01
                                                        : 8'($urandom_range(0, 255));
  endtask

  task automatic test_reset();
    tests++;
    if ({busy, done, err, res_valid, res_data, res_addr, img_addr, flt_addr, mode_o} !== '0) begin
      failed++;
      $display("FAIL reset_state got b%b d%b e%b v%b data=%h ra=%h ia=%h fa=%h m=%b, all zero required",
               busy, done, err, res_valid, res_data, res_addr, img_addr, flt_addr, mode_o);
    end
  endtask

  task automatic run_image(input string name, input int fixed_stall, input bit poke);
    logic [7:0]    exp_d [NWIN];
    logic [7:0]    hd;
    logic [RW-1:0] ha;
    logic [AW-1:0] hi;
    int got = 0, modes = 0, stall = 0;
    bit holding = 0, fin = 0;
    for (int w = 0; w < NWIN; w++) exp_d[w] = ref_win(w / (W - 2), w % (W - 2));
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    tests++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      failed++;
      $display("FAIL %s start_accept busy=%b err=%b, required busy=1 err=0", name, busy, err);
    end
    for (int n = 0; n < 3000 && !fin; n++) begin
      start = (poke && n == 20);
      if (mode_o == 2'b01) modes++;
      if (res_valid) begin
        if (!holding) begin
          holding = 1; hd = res_data; ha = res_addr; hi = img_addr;
          stall = (fixed_stall >= 0) ? fixed_stall : $urandom_range(0, 3);
        end else begin
          tests++;
          if (res_data !== hd || res_addr !== ha || img_addr !== hi) begin
            failed++;
            $display("FAIL %s hold data=%h addr=%h img=%h, required %h %h %h",
                     name, res_data, res_addr, img_addr, hd, ha, hi);
          end
        end
        if (stall > 0) begin
          res_ready = 1'b0;
          stall--;
        end else begin
          res_ready = 1'b1;
          holding = 0;
          tests++;
          if (got >= NWIN) begin
            failed++;
            $display("FAIL %s extra_result addr=%h, only %0d results required", name, res_addr, NWIN);
          end else if (res_data !== exp_d[got] || res_addr !== RW'(got)) begin
            failed++;
            $display("FAIL %s result%0d data=%h addr=%h, required %h %h",
                     name, got, res_data, res_addr, exp_d[got], RW'(got));
          end
          got++;
        end
      end else begin
        res_ready = 1'($urandom_range(0, 1));
      end
      if (done) fin = 1;
      else @(negedge clk);
    end
    start = 1'b0;
    tests++;
    if (!fin || got != NWIN || modes != NWIN * 9 || err !== 1'b0 || busy !== 1'b1) begin
      failed++;
      $display("FAIL %s run_end done_seen=%0d results=%0d pairs=%0d err=%b busy=%b, required 1 %0d %0d 0 1",
               name, fin, got, modes, err, busy, NWIN, NWIN * 9);
    end
    if (poke) start = 1'b1;
    @(negedge clk); start = 1'b0;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL %s after_done done=%b busy=%b, required 0 0", name, done, busy);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || mode_o !== 2'b00) begin
      failed++;
      $display("FAIL %s idle busy=%b mode=%b, required 0 00", name, busy, mode_o);
    end
  endtask

  task automatic test_timeout();
    int n = 1;
    bit saw_valid = 0;
    pe_kill = 1'b1;
    fill(3);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!done && n < 200) begin
      if (res_valid) saw_valid = 1;
      @(negedge clk);
      n++;
    end
    tests++;
    if (n != 9 + TO + 2 || err !== 1'b1 || saw_valid) begin
      failed++;
      $display("FAIL timeout done_cycle=%0d err=%b valid_seen=%0d, required %0d 1 0",
               n, err, saw_valid, 9 + TO + 2);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failed++;
      $display("FAIL timeout_sticky err=%b busy=%b done=%b, required 1 0 0", err, busy, done);
    end
    pe_kill = 1'b0;
  endtask

  task automatic test_midrun_reset();
    int seen = 0, n = 0;
    fill(3);
    res_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (seen < 4 && n < 1000) begin
      if (res_valid) seen++;
      @(negedge clk);
      n++;
    end
    while (!(busy && flt_addr == 4'd3 && mode_o == 2'b01) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 1000) begin
      failed++;
      $display("FAIL midrun_reach windows=%0d, required window 4 fetch", seen);
    end
    #1 rst = 1'b1;
    #1 test_reset();
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    run_image("after_rst", -1, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; res_ready = 1'b0;
    fill(0);
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    fill(0); run_image("ones", -1, 1);
    fill(1); run_image("wrap", -1, 0);
    fill(2); run_image("h90", 0, 0);
    fill(3); run_image("stall5", 5, 0);
    repeat (3) begin
      fill(3); run_image("rand", -1, 0);
    end
    test_timeout();
    fill(0); run_image("after_timeout", -1, 0);
    test_midrun_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
